axis_packet_generator: RTL and testbench

- AXI-Stream master-only source: emits a configurable burst of packets with a deterministic incrementing data pattern.
- Drives tlast at each packet boundary and honours downstream backpressure.
- Sits upstream of stream consumers and register slices as the traffic source for bring-up, loopback and throughput testing.
- Single clock domain.

---
 rtl/axis_packet_generator.sv | 202 ++++++++++++++++++++
 tb/tb_axis_packet_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_generator.sv
// axis_packet_generator
//   AXI-Stream master-only traffic source. On an accepted start it emits
//   cfg_count packets of cfg_len beats each. Beat data is cfg_seed plus the
//   beat's index within the whole burst, wrapping modulo 2^DATA_WIDTH.
//   cfg_gap idle cycles are inserted between packets, but never after the
//   last packet. Downstream backpressure (m_axis_tready) is honoured.
//
// Ports
//   m_axis_aclk    : clock, all logic on the rising edge
//   m_axis_areset  : synchronous reset, active-high, highest priority
//   start          : single-cycle burst request, sampled only in IDLE
//   cfg_len        : beats per packet      (latched on accepted start)
//   cfg_count      : packets per burst     (latched on accepted start)
//   cfg_gap        : idle cycles between packets (latched on accepted start)
//   cfg_seed       : first data word       (latched on accepted start)
//   busy           : high from accepted start until done
//   done           : one-cycle pulse at burst completion
//   pkt_sent       : packets fully accepted in the current/last burst
//   m_axis_tdata   : stream data
//   m_axis_tvalid  : stream valid
//   m_axis_tready  : stream ready from downstream
//   m_axis_tlast   : high on the final beat of each packet
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; zero-length/zero-count bursts finish here
// SEND  | presenting beats; tvalid held until each beat transfers
// GAP   | tvalid low; down-counter times the inter-packet gap
//
// All outputs come straight from flops.

module axis_packet_generator #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_sent,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;          // beats left in packet, incl. current
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  pkt_sent_q, pkt_sent_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;  // gap down-counter, exits at 1
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;
  logic [CNT_WIDTH-1:0]  pkt_next;

  always_comb begin
    xfer     = valid_q && m_axis_tready;
    pkt_next = pkt_sent_q + CNT_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    count_d    = count_q;
    pkt_sent_d = pkt_sent_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          len_d      = cfg_len;
          count_d    = cfg_count;
          gap_d      = cfg_gap;
          pkt_sent_d = '0;
          busy_d     = 1'b1;
          if ((cfg_len == '0) || (cfg_count == '0)) begin
            // Empty burst: busy and done overlap for exactly this one cycle.
            done_d = 1'b1;
          end else begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            data_d  = cfg_seed;
            rem_d   = cfg_len;
            last_d  = (cfg_len == LEN_WIDTH'(1));
          end
        end
      end

      ST_SEND: begin
        if (xfer) begin
          // Data index runs across packet boundaries, so never reload seed.
          data_d = data_q + DATA_WIDTH'(1);
          if (last_q) begin
            pkt_sent_d = pkt_next;
            rem_d      = len_q;
            if (pkt_next == count_q) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q == '0) begin
              last_d = (len_q == LEN_WIDTH'(1));
            end else begin
              state_d   = ST_GAP;
              valid_d   = 1'b0;
              last_d    = 1'b0;
              gap_cnt_d = gap_q;
            end
          end else begin
            rem_d  = rem_q - LEN_WIDTH'(1);
            last_d = (rem_q == LEN_WIDTH'(2));
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          last_d  = (len_q == LEN_WIDTH'(1));
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      pkt_sent_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      pkt_sent_q <= pkt_sent_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_sent      = pkt_sent_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_axis_packet_generator.sv
module tb_axis_packet_generator;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_seed;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  axis_packet_generator dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (areset),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_count     (cfg_count),
    .cfg_gap       (cfg_gap),
    .cfg_seed      (cfg_seed),
    .busy          (busy),
    .done          (done),
    .pkt_sent      (pkt_sent),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rx_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Compare process: every accepted beat is checked against the model queue,
  // and stalled beats must stay put with tvalid held.
  always @(negedge clk) begin
    beat_t e;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (!(tvalid && tdata == prev_data && tlast == prev_last)) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (tvalid && tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got d=%0h l=%0b expected no beat", tdata, tlast);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== e.d || tlast !== e.l) begin
            n_err++;
            $display("FAIL beat: got d=%0h l=%0b expected d=%0h l=%0b", tdata, tlast, e.d, e.l);
          end
          rx_q.push_back(tdata);
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic push_model(input logic [15:0] len, input logic [15:0] cnt, input logic [31:0] seed);
    beat_t b;
    for (int p = 0; p < int'(cnt); p++) begin
      for (int k = 0; k < int'(len); k++) begin
        b.d = seed + 32'(p * int'(len) + k);
        b.l = (k == int'(len) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_burst(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                           input logic [31:0] seed, input bit bp, input bit poke);
    int  cycles;
    int  done_cyc;
    int  first_v;
    int  beats;
    bit  seen_done;
    logic busy_at_done;
    bit  empty;
    empty = (len == 0) || (cnt == 0);
    beats = empty ? 0 : int'(len) * int'(cnt);
    exp_q.delete();
    rx_q.delete();
    push_model(len, cnt, seed);

    cfg_len   = len;
    cfg_count = cnt;
    cfg_gap   = gap;
    cfg_seed  = seed;
    start     = 1'b1;
    tready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_len   = 16'hFFFF;
    cfg_count = 16'hFFFF;
    cfg_gap   = 8'hFF;
    cfg_seed  = 32'hA5A5_A5A5;

    cycles = 0; done_cyc = -1; first_v = -1; seen_done = 0; busy_at_done = 1'b0;
    while (!seen_done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (first_v < 0 && tvalid) first_v = cycles;
      if (done) begin
        seen_done    = 1;
        done_cyc     = cycles;
        busy_at_done = busy;
      end
      @(posedge clk); #1;
      if (bp) tready = 1'($urandom_range(0, 1));
      start = (poke && cycles == 2);
    end
    start  = 1'b0;
    tready = 1'b1;

    chk("done_seen", 64'(seen_done), 64'd1);
    chk("busy_at_done", 64'(busy_at_done), 64'(empty));
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    chk("beats_rx", 64'(rx_q.size()), 64'(beats));
    chk("pkt_sent", 64'(pkt_sent), empty ? 64'd0 : 64'(cnt));
    if (!bp) begin
      chk("first_beat_cycle", 64'(first_v), empty ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
      chk("done_cycle", 64'(done_cyc),
          empty ? 64'd1 : 64'(beats + int'(gap) * (int'(cnt) - 1) + 1));
    end
    @(negedge clk);
    chk("post_done_idle", {61'd0, done, busy, tvalid}, 64'd0);
  endtask

  initial begin
    areset    = 1'b1;
    start     = 1'b1;
    cfg_len   = 16'd4;
    cfg_count = 16'd1;
    cfg_gap   = 8'd0;
    cfg_seed  = 32'h55;
    tready    = 1'b1;

    // Reset held 3 cycles with start asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {10'd0, busy, done, tvalid, tlast, pkt_sent, tdata}, 64'd0);
    end
    @(posedge clk); #1;
    areset = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk("no_beat_after_reset", {62'd0, tvalid, busy}, 64'd0);
    @(posedge clk); #1;

    // Single packet, no backpressure; literal data pins the model.
    run_burst(16'd4, 16'd1, 8'd0, 32'h10, 0, 0);
    chk("lit_d0", 64'(rx_q[0]), 64'h10);
    chk("lit_d1", 64'(rx_q[1]), 64'h11);
    chk("lit_d2", 64'(rx_q[2]), 64'h12);
    chk("lit_d3", 64'(rx_q[3]), 64'h13);

    // Backpressure.
    run_burst(16'd4, 16'd1, 8'd0, 32'h10, 1, 0);
    chk("bp_lit_d3", 64'(rx_q[3]), 64'h13);

    // Multi-packet with and without gap.
    run_burst(16'd3, 16'd2, 8'd2, 32'h0, 0, 0);
    chk("gap_lit_d5", 64'(rx_q[5]), 64'h5);
    run_burst(16'd3, 16'd2, 8'd0, 32'h0, 0, 0);

    // Seed wrap-around.
    run_burst(16'd4, 16'd1, 8'd0, 32'hFFFF_FFFE, 0, 0);
    chk("wrap_d1", 64'(rx_q[1]), 64'hFFFF_FFFF);
    chk("wrap_d2", 64'(rx_q[2]), 64'h0);
    chk("wrap_d3", 64'(rx_q[3]), 64'h1);

    // Single-beat packets: every beat carries tlast (checked by the model).
    run_burst(16'd1, 16'd3, 8'd0, 32'h50, 0, 0);

    // Empty bursts.
    run_burst(16'd0, 16'd1, 8'd0, 32'h77, 0, 0);
    run_burst(16'd4, 16'd0, 8'd3, 32'h77, 0, 0);

    // Start pulsed mid-burst is ignored.
    run_burst(16'd4, 16'd2, 8'd1, 32'h30, 0, 1);

    // Backpressure across packets and gaps.
    run_burst(16'd3, 16'd3, 8'd1, 32'h7, 1, 0);

    // Reset mid-packet: two beats accepted, beat 2 stalled, then reset.
    exp_q.delete();
    rx_q.delete();
    push_model(16'd5, 16'd1, 32'h200);
    cfg_len = 16'd5; cfg_count = 16'd1; cfg_gap = 8'd0; cfg_seed = 32'h200;
    start = 1'b1; tready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; tready = 1'b0;
    @(negedge clk);
    chk("stalled_beat2", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'h202});
    @(posedge clk); #1; areset = 1'b1;
    @(posedge clk); #1; areset = 1'b0;
    @(negedge clk);
    chk("mid_reset_idle", {60'd0, tvalid, busy, done, tlast}, 64'd0);
    chk("mid_reset_pkt", 64'(pkt_sent), 64'd0);
    @(posedge clk); #1;
    tready = 1'b1;
    run_burst(16'd3, 16'd1, 8'd0, 32'h100, 0, 0);
    chk("restart_d0", 64'(rx_q[0]), 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
